// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: left-justified I2S playback serializer.
// Takes left/right sample pairs over a valid/ready handshake into a one-deep
// hold buffer. At each DACLRCK edge it loads the matching channel word and
// shifts it MSB-first onto the DAC data line. All state moves on the falling
// edge of the codec bit clock, so data is stable when the codec samples it on
// the rising edge. A left frame that starts while enabled with an empty hold
// buffer is counted as an underrun and plays silence.
module i2s_dac_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_daclrck,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_left,
    input  logic [DATA_WIDTH-1:0] i_right,
    output logic                  o_ready,
    output logic                  o_dacdat,
    output logic                  o_sample_req,
    output logic                  o_underrun,
    output logic [CNT_WIDTH-1:0]  o_underrun_cnt
);

    // Bit index counter only needs to reach DATA_WIDTH-1.
    localparam int                   BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    // LRCK history for edge detection
    logic lrck_q;

    // One-deep hold buffer fed by the handshake
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;

    // Pair currently being played in this frame
    logic [DATA_WIDTH-1:0] act_l_q, act_l_d;
    logic [DATA_WIDTH-1:0] act_r_q, act_r_d;

    // Serializer: word being sent and index of the bit currently on the line
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [BW-1:0]         nxt_bit;
    logic                  dacdat_q, dacdat_d;

    // Status outputs
    logic                 req_q, req_d;
    logic                 urun_q, urun_d;
    logic [CNT_WIDTH-1:0] ucnt_q, ucnt_d;

    // Frame events
    logic left_start;
    logic right_start;
    logic accept;
    logic consume;
    logic starve;

    // Decode LRCK edges and the handshake / frame-start events
    always_comb begin
        left_start  = lrck_q & ~i_daclrck;
        right_start = ~lrck_q & i_daclrck;
        // Accept uses the hold state from before this cycle; when the hold is
        // full no accept can happen, so accept and consume never collide.
        accept      = i_valid & ~hold_full_q;
        consume     = left_start & i_enable & hold_full_q;
        starve      = left_start & i_enable & ~hold_full_q;
    end

    // Hold buffer: capture on accept, release to the active pair on consume
    always_comb begin
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        if (consume) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = i_left;
            hold_r_d    = i_right;
        end
    end

    // Active pair: chosen once per frame at the left start; silence otherwise
    always_comb begin
        act_l_d = act_l_q;
        act_r_d = act_r_q;
        if (left_start) begin
            if (consume) begin
                act_l_d = hold_l_q;
                act_r_d = hold_r_q;
            end else begin
                act_l_d = '0;
                act_r_d = '0;
            end
        end
    end

    // Serializer: an LRCK edge always reloads, abandoning any unfinished word
    always_comb begin
        nxt_bit  = bit_q - 1'b1;
        word_d   = word_q;
        bit_d    = bit_q;
        dacdat_d = 1'b0;
        if (left_start) begin
            word_d   = act_l_d;
            bit_d    = LAST_BIT;
            dacdat_d = act_l_d[DATA_WIDTH-1];
        end else if (right_start) begin
            word_d   = act_r_q;
            bit_d    = LAST_BIT;
            dacdat_d = act_r_q[DATA_WIDTH-1];
        end else if (bit_q != '0) begin
            bit_d    = nxt_bit;
            dacdat_d = word_q[nxt_bit];
        end
    end

    // Frame-start strobes and saturating underrun count
    always_comb begin
        req_d  = left_start;
        urun_d = starve;
        ucnt_d = ucnt_q;
        if (starve && (ucnt_q != CNT_MAX)) begin
            ucnt_d = ucnt_q + 1'b1;
        end
    end

    // State registers on the falling bit-clock edge, async active-low reset
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_q      <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            act_l_q     <= '0;
            act_r_q     <= '0;
            word_q      <= '0;
            bit_q       <= '0;
            dacdat_q    <= 1'b0;
            req_q       <= 1'b0;
            urun_q      <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            lrck_q      <= i_daclrck;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
            word_q      <= word_d;
            bit_q       <= bit_d;
            dacdat_q    <= dacdat_d;
            req_q       <= req_d;
            urun_q      <= urun_d;
            ucnt_q      <= ucnt_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        o_ready        = ~hold_full_q;
        o_dacdat       = dacdat_q;
        o_sample_req   = req_q;
        o_underrun     = urun_q;
        o_underrun_cnt = ucnt_q;
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx. The driver walks LRCK half-periods and,
// per cycle, predicts the outputs from frame-level rules: which pair a left
// frame plays, and bit j of a half-period being word[DW-1-j] (zero beyond the
// word). A monitor on the rising edge pops and compares.
module tb_i2s_dac_tx;

    localparam int DW   = 16;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    typedef struct packed {
        logic          dat;
        logic          req;
        logic          urun;
        logic          rdy;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          i_enable;
    logic          i_daclrck;
    logic          i_valid;
    logic [DW-1:0] i_left;
    logic [DW-1:0] i_right;
    logic          o_ready;
    logic          o_dacdat;
    logic          o_sample_req;
    logic          o_underrun;
    logic [CW-1:0] o_underrun_cnt;

    i2s_dac_tx #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (i_enable),
        .i_daclrck      (i_daclrck),
        .i_valid        (i_valid),
        .i_left         (i_left),
        .i_right        (i_right),
        .o_ready        (o_ready),
        .o_dacdat       (o_dacdat),
        .o_sample_req   (o_sample_req),
        .o_underrun     (o_underrun),
        .o_underrun_cnt (o_underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: pairs waiting to be offered, hold buffer, playing pair
    exp_t  sb[$];
    pair_t pend[$];
    pair_t hold[$];
    pair_t act;
    bit    prev_lr;
    int    ucnt;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    // Monitor: outputs settled after the falling edge, sampled on the rising edge
    always @(posedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("dacdat", 32'(o_dacdat), 32'(e.dat));
            check("sample_req", 32'(o_sample_req), 32'(e.req));
            check("underrun", 32'(o_underrun), 32'(e.urun));
            check("ready", 32'(o_ready), 32'(e.rdy));
            check("underrun_cnt", 32'(o_underrun_cnt), 32'(e.cnt));
        end
    end

    // One LRCK half-period of len cycles; en is the enable seen at its first cycle
    task automatic half(input bit lr, input int len, input bit en, input int pct);
        logic [DW-1:0] w;
        w = '0;
        for (int j = 0; j < len; j++) begin
            exp_t e;
            bit   v, rdy_now, sl, sr;
            @(posedge clk); #1;
            v         = (pend.size() > 0) && ($urandom_range(99) < pct);
            i_daclrck = lr;
            i_enable  = (j == 0) ? en : 1'($urandom);
            i_valid   = v;
            i_left    = v ? pend[0].l : DW'($urandom);
            i_right   = v ? pend[0].r : DW'($urandom);
            rdy_now   = (hold.size() == 0);
            sl        = (j == 0) && prev_lr && !lr;
            sr        = (j == 0) && !prev_lr && lr;
            e         = '0;
            if (sl) begin
                e.req = 1'b1;
                act   = '0;
                if (en) begin
                    if (hold.size() > 0) act = hold.pop_front();
                    else begin
                        e.urun = 1'b1;
                        if (ucnt < CMAX) ucnt++;
                    end
                end
                w = act.l;
            end else if (sr) begin
                w = act.r;
            end else if (j == 0) begin
                w = '0;
            end
            if (v && rdy_now) hold.push_back(pend.pop_front());
            prev_lr = lr;
            if (j < DW) e.dat = w[DW-1-j];
            else        e.dat = 1'b0;
            e.rdy = (hold.size() == 0);
            e.cnt = CW'(ucnt);
            sb.push_back(e);
        end
    endtask

    task automatic frame(input int ll, input int rl, input bit en, input int pct);
        half(1'b0, ll, en, pct);
        half(1'b1, rl, en, pct);
    endtask

    initial begin
        rst_n     = 1'b0;
        i_enable  = 1'b0;
        i_daclrck = 1'b0;
        i_valid   = 1'b0;
        i_left    = '0;
        i_right   = '0;
        prev_lr   = 1'b0;
        ucnt      = 0;
        act       = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dacdat", 32'(o_dacdat), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_sample_req", 32'(o_sample_req), 32'd0);
        check("rst_underrun", 32'(o_underrun), 32'd0);
        check("rst_cnt", 32'(o_underrun_cnt), 32'd0);
        rst_n = 1'b1;

        // Basic pair plus a second pair held off while the hold is full
        pend.push_back('{l: 16'hA5C3, r: 16'h8001});
        pend.push_back('{l: 16'h1234, r: 16'h5678});
        half(1'b1, 32, 1'b1, 100);
        frame(32, 32, 1'b1, 100);
        frame(32, 32, 1'b1, 0);

        // Three starved frames
        repeat (3) frame(32, 32, 1'b1, 0);

        // Disabled with a full hold: silence, pair retained, then played
        pend.push_back('{l: 16'hBEEF, r: 16'hCAFE});
        frame(32, 32, 1'b0, 100);
        frame(32, 32, 1'b0, 0);
        frame(32, 32, 1'b1, 0);

        // Pair offered on the left-start cycle itself, then a short left half
        pend.push_back('{l: 16'h7E81, r: 16'hF00F});
        frame(32, 32, 1'b1, 100);
        frame(8, 32, 1'b1, 0);

        // Randomized frames: odd half lengths, enable, bursty traffic
        repeat (60) begin
            if (pend.size() < 2 && $urandom_range(1) == 1)
                pend.push_back('{l: DW'($urandom), r: DW'($urandom)});
            frame($urandom_range(4, 40), $urandom_range(4, 40),
                  ($urandom_range(4) != 0), $urandom_range(0, 30));
        end
        pend.delete();

        // Async reset mid-word with a full hold buffer
        half(1'b0, 32, 1'b1, 0);
        half(1'b1, 32, 1'b1, 0);
        pend.push_back('{l: 16'hFFFF, r: 16'hFFFF});
        pend.push_back('{l: 16'h0F0F, r: 16'h0F0F});
        half(1'b1, 32, 1'b1, 100);
        half(1'b0, 5, 1'b1, 100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dacdat", 32'(o_dacdat), 32'd0);
        check("arst_ready", 32'(o_ready), 32'd1);
        check("arst_cnt", 32'(o_underrun_cnt), 32'd0);
        check("arst_underrun", 32'(o_underrun), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
